// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared FPU types and constants for the digit-serial add/sub engine
package fpu_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } addsub_state_t;

   localparam int DIGIT_W = 3;

endpackage

// File: rtl/addsub_digit3.sv
// rtl/addsub_digit3.sv - combinational 3-bit add/sub slice built from three full adders
module addsub_digit3
   import fpu_pkg::*;
(
   input  logic [DIGIT_W-1:0] a,
   input  logic [DIGIT_W-1:0] b,
   input  logic               sub,
   input  logic               cin,
   output logic [DIGIT_W-1:0] sum,
   output logic               cout,
   output logic               c_msb
);

   logic [DIGIT_W:0]   c;
   logic [DIGIT_W-1:0] bx;

   // Subtraction inverts B here; the +1 arrives through cin from the controller.
   assign bx   = b ^ {DIGIT_W{sub}};
   assign c[0] = cin;

   for (genvar i = 0; i < DIGIT_W; i++) begin : g_fa
      assign sum[i]  = a[i] ^ bx[i] ^ c[i];
      assign c[i+1]  = (a[i] & bx[i]) | (c[i] & (a[i] ^ bx[i]));
   end

   // Raw carry out; borrow conversion is left to the controller.
   assign cout  = c[DIGIT_W];
   assign c_msb = c[DIGIT_W-1];

endmodule

// File: rtl/serial_addsub_ctrl.sv
// rtl/serial_addsub_ctrl.sv - digit-serial add/sub controller with valid/ready and C/V/Z flags
module serial_addsub_ctrl
   import fpu_pkg::*;
#(
   parameter int WIDTH = 24
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   input  logic             abort,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             c_flag,
   output logic             v_flag,
   output logic             z_flag
);

   localparam int N     = WIDTH / DIGIT_W;
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

   if ((WIDTH % DIGIT_W) != 0 || WIDTH < DIGIT_W) begin : g_bad_width
      $error("serial_addsub_ctrl: WIDTH must be a positive multiple of 3");
   end

   addsub_state_t      state;
   logic [WIDTH-1:0]   a_sh;
   logic [WIDTH-1:0]   b_sh;
   logic               sub_r;
   logic               carry;
   logic [CNT_W-1:0]   cnt;

   logic [DIGIT_W-1:0] d_sum;
   logic               d_cout;
   logic               d_cmsb;
   logic [WIDTH-1:0]   res_next;

   assign in_ready = (state == IDLE);

   // Operands are shifted right each digit so the slice always sees bits [2:0].
   addsub_digit3 u_digit (
      .a     (a_sh[DIGIT_W-1:0]),
      .b     (b_sh[DIGIT_W-1:0]),
      .sub   (sub_r),
      .cin   (carry),
      .sum   (d_sum),
      .cout  (d_cout),
      .c_msb (d_cmsb)
   );

   // Result with the current digit merged in, so z_flag sees the final value on the last digit.
   always_comb begin
      res_next = result;
      res_next[int'(cnt) * DIGIT_W +: DIGIT_W] = d_sum;
   end

   // Control FSM plus digit datapath and flag registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         a_sh      <= '0;
         b_sh      <= '0;
         sub_r     <= 1'b0;
         carry     <= 1'b0;
         cnt       <= '0;
         result    <= '0;
         c_flag    <= 1'b0;
         v_flag    <= 1'b0;
         z_flag    <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_sh  <= a;
                  b_sh  <= b;
                  sub_r <= sub;
                  carry <= sub;
                  cnt   <= '0;
                  state <= RUN;
               end
            end
            RUN: begin
               if (abort) begin
                  state <= IDLE;
               end else begin
                  result <= res_next;
                  carry  <= d_cout;
                  a_sh   <= a_sh >> DIGIT_W;
                  b_sh   <= b_sh >> DIGIT_W;
                  if (cnt == LAST) begin
                     c_flag    <= d_cout ^ sub_r;
                     v_flag    <= d_cmsb ^ d_cout;
                     z_flag    <= (res_next == '0);
                     out_valid <= 1'b1;
                     state     <= DONE;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            DONE: begin
               // abort and out_ready both retire the operation; neither needs priority here.
               if (abort || out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// tb/tb_serial_addsub_ctrl.sv - self-checking bench for serial_addsub_ctrl at WIDTH=12
module tb_serial_addsub_ctrl;

   localparam int W = 12;
   localparam int N = W / 3;

   typedef struct packed {
      logic [W-1:0] r;
      logic         c;
      logic         v;
      logic         z;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         sub = 1'b0;
   logic         abort = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] result;
   logic         c_flag;
   logic         v_flag;
   logic         z_flag;

   int   errors = 0;
   int   checks = 0;
   exp_t sb[$];
   exp_t held;

   serial_addsub_ctrl #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .sub       (sub),
      .abort     (abort),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .c_flag    (c_flag),
      .v_flag    (v_flag),
      .z_flag    (z_flag)
   );

   always #5 clk = ~clk;

   function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
      logic [W:0]   full;
      logic [W-1:0] low;
      logic [W-1:0] yb;
      exp_t         e;
      yb   = s ? ~y : y;
      full = {1'b0, x} + {1'b0, yb} + (W+1)'(s);
      low  = {1'b0, x[W-2:0]} + {1'b0, yb[W-2:0]} + W'(s);
      e.r  = full[W-1:0];
      e.c  = full[W] ^ s;
      e.v  = low[W-1] ^ full[W];
      e.z  = (full[W-1:0] == '0);
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_outputs(input string tag, input exp_t e);
      chk({tag, "_result"}, 32'(result), 32'(e.r));
      chk({tag, "_c"}, 32'(c_flag), 32'(e.c));
      chk({tag, "_v"}, 32'(v_flag), 32'(e.v));
      chk({tag, "_z"}, 32'(z_flag), 32'(e.z));
   endtask

   // Drive one request at a negedge while idle; returns at the negedge after the accept edge.
   task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic isub);
      chk("in_ready_before_issue", 32'(in_ready), 32'd1);
      a        = ia;
      b        = ib;
      sub      = isub;
      in_valid = 1'b1;
      sb.push_back(model(ia, ib, isub));
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // Wait (bounded) for out_valid, check latency and pop the scoreboard.
   task automatic wait_result(input string tag, output exp_t e);
      int cycles;
      cycles = 0;
      e = '0;
      while (out_valid !== 1'b1 && cycles < 20) begin
         @(negedge clk);
         cycles++;
      end
      chk({tag, "_latency"}, 32'(cycles), 32'(N));
      chk({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
      if (out_valid === 1'b1 && sb.size() != 0) begin
         e = sb.pop_front();
         chk_outputs(tag, e);
      end
   endtask

   task automatic drain(input string tag);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk({tag, "_out_valid_drop"}, 32'(out_valid), 32'd0);
      chk({tag, "_in_ready_back"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      exp_t e;

      // Reset state, checked before any clock edge.
      #1 rst = 1'b1;
      #1;
      chk_outputs("reset", '0);
      chk("reset_out_valid", 32'(out_valid), 32'd0);
      chk("reset_in_ready", 32'(in_ready), 32'd1);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      issue(12'h7FF, 12'h001, 1'b0);
      wait_result("add_7ff_1", e);
      drain("add_7ff_1");

      issue(12'h005, 12'h007, 1'b1);
      wait_result("sub_5_7", e);
      drain("sub_5_7");

      issue(12'h123, 12'h123, 1'b1);
      wait_result("sub_eq", e);
      drain("sub_eq");

      issue(12'hFFF, 12'h001, 1'b0);
      wait_result("add_wrap", e);
      drain("add_wrap");

      issue(12'h800, 12'h001, 1'b1);
      wait_result("sub_ovf", e);
      drain("sub_ovf");

      // Backpressure: hold 5 cycles with a competing request that must be ignored.
      issue(12'h3A5, 12'h1C7, 1'b0);
      wait_result("bp", held);
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         a        = 12'hABC;
         b        = 12'h111;
         sub      = 1'b1;
         @(negedge clk);
         chk("bp_out_valid_held", 32'(out_valid), 32'd1);
         chk("bp_in_ready_low", 32'(in_ready), 32'd0);
         chk_outputs("bp_stable", held);
      end
      in_valid = 1'b0;
      drain("bp");
      chk_outputs("idle_hold", held);
      @(negedge clk);
      chk("bp_no_late_accept", 32'(in_ready), 32'd1);

      // Abort at the second RUN edge.
      issue(12'h456, 12'h321, 1'b0);
      @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      void'(sb.pop_back());
      chk("abort_run_in_ready", 32'(in_ready), 32'd1);
      chk("abort_run_out_valid", 32'(out_valid), 32'd0);
      repeat (N + 2) @(negedge clk);
      chk("abort_run_never_valid", 32'(out_valid), 32'd0);

      // Abort in DONE together with out_ready.
      issue(12'h0F0, 12'h00F, 1'b1);
      wait_result("abort_done", e);
      abort     = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      abort     = 1'b0;
      out_ready = 1'b0;
      chk("abort_done_out_valid", 32'(out_valid), 32'd0);
      chk("abort_done_in_ready", 32'(in_ready), 32'd1);

      // Random operands.
      for (int i = 0; i < 6; i++) begin
         issue(W'($urandom_range(0, 4095)), W'($urandom_range(0, 4095)), 1'($urandom_range(0, 1)));
         wait_result("rand", e);
         drain("rand");
      end

      // Set all flags, then reset mid-RUN without a clock edge.
      issue(12'h800, 12'h800, 1'b0);
      wait_result("add_ovf_carry", e);
      drain("add_ovf_carry");
      issue(12'h123, 12'h456, 1'b0);
      @(negedge clk);
      #1 rst = 1'b1;
      #1;
      void'(sb.pop_back());
      chk_outputs("rst_mid_run", '0);
      chk("rst_mid_run_out_valid", 32'(out_valid), 32'd0);
      chk("rst_mid_run_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      issue(12'hA5A, 12'h5A5, 1'b0);
      wait_result("post_rst", e);
      drain("post_rst");

      chk("sb_empty_at_end", 32'(sb.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
